mem_io_bridge: RTL
==================

// Module: mem_io_bridge
// PURPOSE
//  Sits between the SimpleCPU memory port and the block RAM; decodes every CPU access by address.
//  Low addresses pass straight to RAM; the top window (IO_BASE..) is a small memory-mapped I/O page.
//  The I/O page holds an output FIFO with a valid/ready drain port, a status/overflow register,
//  a loadable free-running timer and a synchronised input port. Read latency seen by the CPU is
//  the same one cycle the RAM gives, so the CPU state machine runs unchanged.
// PARAMETERS
//  SIZE        10      address width, identical to the CPU SIZE
//  IO_BASE     10'h3F8 first I/O address; addresses >= IO_BASE never reach RAM
//  FIFO_DEPTH  4       output FIFO entries, power of two, 2..16
//  IN_W        16      width of gpio_in
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst_n        in   1     reset, asynchronous assert, active-low
//  cpu_wrEn     in   1     CPU write strobe (combinational from CPU)
//  cpu_addr     in   SIZE  CPU address
//  cpu_wdata    in   32    CPU write data
//  cpu_rdata    out  32    read data to CPU, valid the cycle after cpu_addr is presented
//  ram_wrEn     out  1     RAM write strobe
//  ram_addr     out  SIZE  RAM address
//  ram_wdata    out  32    RAM write data
//  ram_rdata    in   32    RAM synchronous-read data (1-cycle latency)
//  out_valid    out  1     FIFO head valid
//  out_data     out  32    FIFO head word
//  out_ready    in   1     consumer accepts head when out_valid & out_ready
//  gpio_in      in   IN_W  asynchronous external input
// BEHAVIOUR
//  RAM path: ram_addr = cpu_addr, ram_wdata = cpu_wdata always; ram_wrEn = cpu_wrEn & (cpu_addr < IO_BASE).
//  Read select: each edge registers sel_io = (cpu_addr >= IO_BASE) and io_q = I/O read value at
//   cpu_addr. cpu_rdata = sel_io ? io_q : ram_rdata. Reads have no side effects.
//  I/O map (offset from IO_BASE; other offsets read 0, writes ignored):
//   +0 OUT  : write pushes cpu_wdata into FIFO; read returns 0.
//   +1 STAT : read {26'b0, ovf, full, empty, count[2:0]} (count saturates at 7 in this field);
//             write with cpu_wdata[0]=1 clears ovf.
//   +2 TIMER: 32-bit, +1 every cycle, wraps FFFF_FFFF->0; write loads cpu_wdata (no increment that
//             cycle). Read returns the value before that edge's update.
//   +3 GPIO : gpio_in through 2-flop synchroniser; read returns second-flop value; writes ignored.
//  FIFO: circular buffer, wr_ptr/rd_ptr log2(FIFO_DEPTH) bits plus count 0..FIFO_DEPTH.
//   push = write to +0; accepted iff count < FIFO_DEPTH (pre-edge count).
//   pop  = out_valid & out_ready. out_valid = (count != 0); out_data = mem[rd_ptr].
//   Push while full: word dropped, ovf set (sticky). A same-cycle pop does NOT make room for it.
//   Push + pop same edge (not full): count unchanged, both pointers advance.
//   STAT write clearing ovf in the same cycle as an overflowing push: set wins, ovf stays 1.
//   Pointers wrap modulo FIFO_DEPTH.
//  Reset (rst_n=0, async): count, pointers, FIFO storage, ovf, timer, sync flops, sel_io, io_q all
//   cleared; sel_io reset selects I/O so cpu_rdata=0; out_valid=0, out_data=0.
//   ram_* stay combinational pass-through. On reset release the timer counts from 0 on the first edge.
//  Reset mid-operation discards FIFO contents and any in-flight read.
// TESTING
//  1 RAM pass: write 0x1234 to addr 5, read addr 5 -> ram_wrEn=1 once, cpu_rdata=0x1234 one cycle later.
//  2 FIFO order: push 0xA,0xB,0xC with out_ready=0 -> STAT reads count=3, empty=0; raise
//    out_ready -> out_data 0xA,0xB,0xC on consecutive cycles, then out_valid=0.
//  3 Overflow: push 5 words into depth 4 with out_ready=0 -> 5th dropped, ovf=1, no RAM write;
//    STAT write 1 -> ovf=0.
//  4 Simultaneous: count=2, push and pop in the same cycle -> count stays 2, order preserved;
//    when full, push+pop -> push dropped, ovf=1, count=3.
//  5 Timer: write 0xFFFF_FFFE to +2, read two cycles later -> 0xFFFF_FFFF then 0 (wrap).
//  6 Async reset mid-drain: assert rst_n low between edges -> out_valid, cpu_rdata, timer at 0
//    immediately; gpio_in=0x5A5A appears in a GPIO read only after 2 synchroniser edges.

Source files
------------

// File: rtl/mem_io_bridge.sv
// -----------------------------------------------------------------------------
// mem_io_bridge
// Sits between the SimpleCPU memory port and the block RAM. Every CPU access is
// decoded by address: addresses below IO_BASE go straight to RAM, and addresses
// from IO_BASE upward form a small memory-mapped I/O page.
//
// The I/O page (offset from IO_BASE) contains:
//   +0 OUT   write pushes a word into the output FIFO (reads as 0)
//   +1 STAT  {26'b0, ovf, full, empty, count[2:0]}; writing bit0=1 clears ovf
//   +2 TIMER free-running 32-bit counter, loadable by a write
//   +3 GPIO  gpio_in after a two-flop synchroniser (read only)
//   other offsets read 0 and ignore writes
//
// Read data reaches the CPU one cycle after the address, which matches the
// RAM's own latency, so the CPU state machine does not need to change.
//
// Ports
//   clk        in   1     clock, all state updates on the rising edge
//   rst_n      in   1     asynchronous active-low reset
//   cpu_wrEn   in   1     CPU write strobe
//   cpu_addr   in   SIZE  CPU address
//   cpu_wdata  in   32    CPU write data
//   cpu_rdata  out  32    read data, valid the cycle after cpu_addr
//   ram_wrEn   out  1     RAM write strobe (RAM-window writes only)
//   ram_addr   out  SIZE  RAM address (pass-through)
//   ram_wdata  out  32    RAM write data (pass-through)
//   ram_rdata  in   32    RAM synchronous read data
//   out_valid  out  1     output FIFO head valid
//   out_data   out  32    output FIFO head word
//   out_ready  in   1     consumer accepts the head word
//   gpio_in    in   IN_W  asynchronous external input
// -----------------------------------------------------------------------------
module mem_io_bridge #(
    parameter int          SIZE       = 10,
    parameter int unsigned IO_BASE    = 32'h3F8,
    parameter int          FIFO_DEPTH = 4,
    parameter int          IN_W       = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cpu_wrEn,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [31:0]     cpu_wdata,
    output logic [31:0]     cpu_rdata,
    output logic            ram_wrEn,
    output logic [SIZE-1:0] ram_addr,
    output logic [31:0]     ram_wdata,
    input  logic [31:0]     ram_rdata,
    output logic            out_valid,
    output logic [31:0]     out_data,
    input  logic            out_ready,
    input  logic [IN_W-1:0] gpio_in
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // ---------------------------------------------------------------- decode
    logic        is_io;
    logic [31:0] io_off;
    logic        wr_out;
    logic        wr_stat;
    logic        wr_timer;

    always_comb begin
        is_io    = (32'(cpu_addr) >= IO_BASE);
        io_off   = 32'(cpu_addr) - IO_BASE;
        wr_out   = cpu_wrEn && is_io && (io_off == 32'd0);
        wr_stat  = cpu_wrEn && is_io && (io_off == 32'd1);
        wr_timer = cpu_wrEn && is_io && (io_off == 32'd2);
    end

    // RAM path is a pure pass-through apart from masking I/O-window writes.
    assign ram_addr  = cpu_addr;
    assign ram_wdata = cpu_wdata;
    assign ram_wrEn  = cpu_wrEn && !is_io;

    // ---------------------------------------------------------------- FIFO
    logic [31:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop;

    always_comb begin
        full    = (count_q == CW'(FIFO_DEPTH));
        empty   = (count_q == '0);
        // Acceptance uses the pre-edge count: a pop in the same cycle does not
        // free a slot for a push arriving while full.
        push_ok = wr_out && !full;
        pop     = !empty && out_ready;

        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end

        // Overflow set takes priority over a clear in the same cycle.
        ovf_d = ovf_q;
        if (wr_stat && cpu_wdata[0]) begin
            ovf_d = 1'b0;
        end
        if (wr_out && full) begin
            ovf_d = 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_word
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    fifo_mem_q[gi] <= '0;
                end else if (push_ok && (wr_ptr_q == PW'(gi))) begin
                    fifo_mem_q[gi] <= cpu_wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = !empty;
    assign out_data  = fifo_mem_q[rd_ptr_q];

    // ---------------------------------------------------------------- timer
    logic [31:0] timer_q, timer_d;

    always_comb begin
        timer_d = wr_timer ? cpu_wdata : timer_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // ---------------------------------------------------------------- GPIO sync
    logic [IN_W-1:0] sync1_q;
    logic [IN_W-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
        end
    end

    // ---------------------------------------------------------------- read path
    logic [31:0] count_ext;
    logic [2:0]  stat_cnt;
    logic [31:0] io_rd;
    logic [31:0] io_q;
    logic        sel_io_q;

    always_comb begin
        count_ext = 32'(count_q);
        // Status field is only 3 bits wide; deeper FIFOs saturate at 7.
        stat_cnt  = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];

        io_rd = '0;
        if (is_io) begin
            case (io_off)
                32'd1:   io_rd = {26'b0, ovf_q, full, empty, stat_cnt};
                32'd2:   io_rd = timer_q;
                32'd3:   io_rd = 32'(sync2_q);
                default: io_rd = '0;
            endcase
        end
    end

    // Reset selects the (cleared) I/O register so the CPU sees 0, not
    // whatever the RAM happens to present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_io_q <= 1'b1;
            io_q     <= '0;
        end else begin
            sel_io_q <= is_io;
            io_q     <= io_rd;
        end
    end

    assign cpu_rdata = sel_io_q ? io_q : ram_rdata;

endmodule
